// File: rtl/fir_filter_pkg.sv
// Shared widths, coefficients and helpers for the dual-channel IQ FIR post-filter.
// FIR_ROUND_EN selects round-half-up instead of floor before saturation.
package fir_filter_pkg;

    localparam int IN_W      = 8;
    localparam int OUT_W     = 4;
    localparam int NTAPS     = 8;
    localparam int OUT_SHIFT = 9;
    localparam int ACC_W     = 16;

    typedef logic signed [IN_W-1:0]  sample_t;
    typedef logic signed [OUT_W-1:0] out_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    // Symmetric low-pass taps, sum 32, so DC gain after the shift is 1/16.
    localparam acc_t COEFS [NTAPS] = '{
        16'sd1, 16'sd2, 16'sd4, 16'sd9, 16'sd9, 16'sd4, 16'sd2, 16'sd1
    };

    localparam acc_t ROUND_BIAS = acc_t'(1 << (OUT_SHIFT - 1));
    localparam acc_t OUT_MAX    = acc_t'((1 << (OUT_W - 1)) - 1);
    localparam acc_t OUT_MIN    = acc_t'(-(1 << (OUT_W - 1)));

    function automatic out_t saturate(input acc_t y);
        out_t r;
        if (y > OUT_MAX) begin
            r = OUT_MAX[OUT_W-1:0];
        end else if (y < OUT_MIN) begin
            r = OUT_MIN[OUT_W-1:0];
        end else begin
            r = y[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_channel.sv
// One filter path: delay line, multiply-accumulate, shift and saturation.
// FIR_ROUND_EN adds half an output LSB to the accumulator before the shift.
module fir_channel
    import fir_filter_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             shift_en,
    input  logic [IN_W-1:0]  sample_in,
    output logic [OUT_W-1:0] sample_out
);

    sample_t taps_q [NTAPS];
    sample_t taps_d [NTAPS];
    out_t    out_q;
    out_t    out_d;
    acc_t    acc;
    acc_t    y;

    // The MAC works on the post-shift delay line so the new sample appears in this result.
    always_comb begin
        taps_d = taps_q;
        if (shift_en) begin
            taps_d[0] = sample_t'(sample_in);
            for (int k = 1; k < NTAPS; k++) begin
                taps_d[k] = taps_q[k-1];
            end
        end

        acc = '0;
        for (int k = 0; k < NTAPS; k++) begin
            acc = acc + acc_t'(taps_d[k]) * COEFS[k];
        end
`ifdef FIR_ROUND_EN
        acc = acc + ROUND_BIAS;
`else
        acc = acc + acc_t'(0);
`endif
        y     = acc >>> OUT_SHIFT;
        out_d = shift_en ? saturate(y) : out_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < NTAPS; k++) begin
                taps_q[k] <= '0;
            end
            out_q <= '0;
        end else begin
            taps_q <= taps_d;
            out_q  <= out_d;
        end
    end

    assign sample_out = out_q;

endmodule

// File: rtl/iq_fir_filter.sv
// Dual-channel (I/Q) low-pass FIR post-filter with a shared one-cycle ready pulse.
// FIR_ROUND_EN switches both channels from floor to round-half-up.
module iq_fir_filter
    import fir_filter_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sample_ready,
    input  logic [IN_W-1:0]  I_IF,
    input  logic [IN_W-1:0]  Q_IF,
    output logic [OUT_W-1:0] I_BB_postfilter,
    output logic [OUT_W-1:0] Q_BB_postfilter,
    output logic             postfilter_ready
);

    logic ready_q;
    logic ready_d;

    always_comb begin
        ready_d = sample_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign postfilter_ready = ready_q;

    fir_channel u_chan_i (
        .clk        (clk),
        .reset_n    (reset_n),
        .shift_en   (sample_ready),
        .sample_in  (I_IF),
        .sample_out (I_BB_postfilter)
    );

    fir_channel u_chan_q (
        .clk        (clk),
        .reset_n    (reset_n),
        .shift_en   (sample_ready),
        .sample_in  (Q_IF),
        .sample_out (Q_BB_postfilter)
    );

endmodule

// File: tb/tb_iq_fir_filter.sv
// Self-checking bench for iq_fir_filter: table of directed vectors, hand sequences
// for resets and gaps, then random traffic against a queue-based reference model.
module tb_iq_fir_filter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sample_ready;
    logic [7:0] I_IF;
    logic [7:0] Q_IF;
    logic [3:0] I_BB_postfilter;
    logic [3:0] Q_BB_postfilter;
    logic       postfilter_ready;

    int total = 0;
    int bad   = 0;

    localparam int REF_C [8] = '{1, 2, 4, 9, 9, 4, 2, 1};

    int hist_i [$];
    int hist_q [$];
    int m_i, m_q, m_r;

    typedef struct {
        bit    rst_n;
        bit    sr;
        int    i;
        int    q;
        int    ei;
        int    eq;
        int    eir;
        int    eqr;
        int    er;
        string name;
    } vec_t;

    vec_t vecs [$];

    int step_f [8] = '{0, 0, 0, 1, 2, 3, 3, 3};
    int step_r [8] = '{0, 0, 1, 2, 3, 3, 3, 4};
    int imp_if [8] = '{0, 0, 0, 2, 2, 0, 0, 0};
    int imp_qf [8] = '{-1, -1, -1, -3, -3, -1, -1, -1};
    int imp_ir [8] = '{0, 0, 1, 2, 2, 1, 0, 0};
    int imp_qr [8] = '{0, 0, -1, -2, -2, -1, 0, 0};
    int ext_if [8] = '{0, 0, 1, 3, 6, 7, 7, 7};
    int ext_qf [8] = '{-1, -1, -2, -4, -7, -8, -8, -8};
    int ext_ir [8] = '{0, 1, 2, 4, 6, 7, 7, 7};
    int ext_qr [8] = '{0, -1, -2, -4, -6, -7, -8, -8};

    iq_fir_filter dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .sample_ready     (sample_ready),
        .I_IF             (I_IF),
        .Q_IF             (Q_IF),
        .I_BB_postfilter  (I_BB_postfilter),
        .Q_BB_postfilter  (Q_BB_postfilter),
        .postfilter_ready (postfilter_ready)
    );

    always #10 clk = ~clk;

    // Reference output from the last eight samples, newest first, using plain integer maths.
    function automatic int ref_out(input int h [$]);
        int acc;
        int y;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            acc += REF_C[k] * h[k];
        end
`ifdef FIR_ROUND_EN
        acc += 256;
`endif
        if (acc >= 0) y = acc / 512;
        else          y = -((-acc + 511) / 512);
        if (y > 7)  y = 7;
        if (y < -8) y = -8;
        return y;
    endfunction

    task automatic clear_model();
        hist_i.delete();
        hist_q.delete();
        for (int k = 0; k < 8; k++) begin
            hist_i.push_back(0);
            hist_q.push_back(0);
        end
        m_i = 0;
        m_q = 0;
        m_r = 0;
    endtask

    task automatic applyStimulus(input bit rst_n, input bit sr, input int i, input int q);
        @(negedge clk);
        reset_n      = rst_n;
        sample_ready = sr;
        I_IF         = i[7:0];
        Q_IF         = q[7:0];
        if (!rst_n) begin
            clear_model();
        end else begin
            m_r = sr ? 1 : 0;
            if (sr) begin
                hist_i.push_front(i);
                void'(hist_i.pop_back());
                hist_q.push_front(q);
                void'(hist_q.pop_back());
                m_i = ref_out(hist_i);
                m_q = ref_out(hist_q);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int ei, input int eq, input int er);
        int ai, aq, ar;
        ai = $signed(I_BB_postfilter);
        aq = $signed(Q_BB_postfilter);
        ar = postfilter_ready ? 1 : 0;
        total++;
        if (ai != ei || aq != eq || ar != er) begin
            bad++;
            $display("[TB] FAIL %s: got I=%0d Q=%0d rdy=%0d, expected I=%0d Q=%0d rdy=%0d",
                     name, ai, aq, ar, ei, eq, er);
        end
    endtask

    task automatic add_vec(input bit rst_n, input bit sr, input int i, input int q,
                           input int ei, input int eq, input int eir, input int eqr,
                           input int er, input string name);
        vec_t v;
        v.rst_n = rst_n; v.sr = sr; v.i = i; v.q = q;
        v.ei = ei; v.eq = eq; v.eir = eir; v.eqr = eqr; v.er = er; v.name = name;
        vecs.push_back(v);
    endtask

    function automatic int pick(input int f, input int r);
`ifdef FIR_ROUND_EN
        return r;
`else
        return f;
`endif
    endfunction

    initial begin
        reset_n      = 1'b0;
        sample_ready = 1'b0;
        I_IF         = '0;
        Q_IF         = '0;
        clear_model();

        for (int n = 0; n < 2; n++) add_vec(0, 1, 127, 127, 0, 0, 0, 0, 0, "reset");
        for (int n = 0; n < 30; n++) add_vec(1, 1, 0, 0, 0, 0, 0, 0, 1, "zeros");
        for (int n = 0; n < 8; n++)
            add_vec(1, 1, (n == 0) ? 127 : 0, (n == 0) ? -128 : 0,
                    imp_if[n], imp_qf[n], imp_ir[n], imp_qr[n], 1, "impulse");
        for (int n = 0; n < 2; n++) add_vec(1, 1, 0, 0, 0, 0, 0, 0, 1, "impulse_tail");
        for (int n = 0; n < 12; n++)
            add_vec(1, 1, 56, 56, step_f[(n < 8) ? n : 7], step_f[(n < 8) ? n : 7],
                    step_r[(n < 8) ? n : 7], step_r[(n < 8) ? n : 7], 1, "step");
        add_vec(0, 1, 56, 56, 0, 0, 0, 0, 0, "step_reset");
        for (int n = 0; n < 10; n++)
            add_vec(1, 1, 127, -128, ext_if[(n < 8) ? n : 7], ext_qf[(n < 8) ? n : 7],
                    ext_ir[(n < 8) ? n : 7], ext_qr[(n < 8) ? n : 7], 1, "extremes");

        foreach (vecs[n]) begin
            applyStimulus(vecs[n].rst_n, vecs[n].sr, vecs[n].i, vecs[n].q);
            checkOutput(vecs[n].name, pick(vecs[n].ei, vecs[n].eir),
                        pick(vecs[n].eq, vecs[n].eqr), vecs[n].er);
        end

        // Reset in the middle of a step must restart the step from scratch.
        applyStimulus(0, 1, 56, 56);
        checkOutput("midreset_a", 0, 0, 0);
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1, 1, 56, 56);
            checkOutput("midreset_pre", pick(step_f[n], step_r[n]), pick(step_f[n], step_r[n]), 1);
        end
        applyStimulus(0, 1, 56, 56);
        checkOutput("midreset_b", 0, 0, 0);
        for (int n = 0; n < 4; n++) begin
            applyStimulus(1, 1, 56, 56);
            checkOutput("midreset_post", pick(step_f[n], step_r[n]), pick(step_f[n], step_r[n]), 1);
        end

        // Gapped step: idle cycles hold the output, drop ready, and ignore the inputs.
        applyStimulus(0, 0, 0, 0);
        checkOutput("gap_reset", 0, 0, 0);
        for (int n = 0; n < 8; n++) begin
            applyStimulus(1, 1, 56, 56);
            checkOutput("gap_accept", pick(step_f[n], step_r[n]), pick(step_f[n], step_r[n]), 1);
            applyStimulus(1, 0, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
            checkOutput("gap_idle", pick(step_f[n], step_r[n]), pick(step_f[n], step_r[n]), 0);
        end

        for (int n = 0; n < 400; n++) begin
            int ri, rq;
            if ($urandom_range(0, 3) == 0) begin
                ri = ($urandom_range(0, 1) == 1) ? 127 : -128;
                rq = ($urandom_range(0, 1) == 1) ? 127 : -128;
            end else begin
                ri = $urandom_range(0, 255) - 128;
                rq = $urandom_range(0, 255) - 128;
            end
            applyStimulus($urandom_range(0, 39) != 0, $urandom_range(0, 3) != 0, ri, rq);
            checkOutput("random", m_i, m_q, m_r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iq_fir_filter.md
Name:
iq_fir_filter

Overview:
- Dual-channel (I and Q) low-pass FIR post-filter in the ZigBee receive/decoder path.
- Takes 8-bit signed IF samples on a sample strobe and produces 4-bit signed filtered baseband samples for the downstream demodulator.
- Each output is flagged with a one-cycle ready pulse.
- I and Q use identical, independent filter paths with shared fixed coefficients.

Parameters:
- IN_W, 8, input sample width (signed two's complement).
- OUT_W, 4, output sample width (signed two's complement).
- NTAPS, 8, number of filter taps; must match the package coefficient array length.
- OUT_SHIFT, 9, arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  system clock (50 MHz), rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- sample_ready  in  1  input strobe; I_IF/Q_IF are valid in this cycle.
- I_IF  in  IN_W  I input sample, signed.
- Q_IF  in  IN_W  Q input sample, signed.
- I_BB_postfilter  out  OUT_W  filtered I sample, signed.
- Q_BB_postfilter  out  OUT_W  filtered Q sample, signed.
- postfilter_ready  out  1  one-cycle-per-sample valid flag for both outputs.

Behaviour:
- Clock/reset: one clock, clk. Reset reset_n is synchronous, active-low: with reset_n=0 at a rising clk edge, the following are cleared to 0:
  - all delay-line registers;
  - I_BB_postfilter and Q_BB_postfilter;
  - postfilter_ready.
- Reset overrides sample_ready in the same cycle. Reset mid-stream discards all filter history.
- Coefficients: symmetric, C[0..7] = {1,2,4,9,9,4,2,1}, sum 32.
- Accept: at a rising edge with sample_ready=1, each channel shifts the new sample into delay-line tap 0. Older samples move up one tap; the tap-7 sample is dropped.
- Compute, per channel, with x[0] = the newest sample:
  - acc = sum over k of C[k]*x[k], signed, 16-bit; no overflow is possible.
  - y = acc >>> OUT_SHIFT (arithmetic shift, floor).
  - Saturate y to [-8, +7].
- Latency: outputs and postfilter_ready are registered. They update at the same edge that accepts the sample, so they are visible in the cycle after sample_ready is sampled high. The new sample is included in that result.
- postfilter_ready:
  - 1 for exactly the cycle following each accepted sample, 0 otherwise.
  - With sample_ready held high continuously, it stays high every cycle after the first acceptance.
- When sample_ready=0: delay lines and output values hold; postfilter_ready=0.
- DC gain is 32/512 = 1/16. A full-scale input therefore never saturates with the default coefficients, but the saturation logic is still required.

Optional Feature:
- Macro: FIR_ROUND_EN.
- Defined: add 2^(OUT_SHIFT-1) (=256) to acc before the shift, giving round-half-up.
- Undefined: plain floor (truncating arithmetic shift).
- Saturation is applied after rounding in both cases.

Decomposition:
- Shared package fir_filter_pkg holds:
  - IN_W, OUT_W, NTAPS, OUT_SHIFT, ACC_W=16;
  - the coefficient array constant COEFS;
  - typedefs sample_t (signed IN_W), out_t (signed OUT_W) and acc_t (signed ACC_W).
- One sub-module, fir_channel: delay line, MAC, shift, saturation for a single channel.
- The top instantiates fir_channel twice (I, Q) and generates postfilter_ready.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with sample_ready=1, I_IF=Q_IF=0x7F -> outputs 0, postfilter_ready 0 throughout reset.
- Zero stream: release reset with sample_ready=1, inputs 0 for 30 cycles -> outputs 0; postfilter_ready high from the cycle after the first accepted sample onward.
- Step: after zeros, hold I_IF=Q_IF=56 -> successive outputs 0,0,0,1,2,3,3,3 then steady 3. With FIR_ROUND_EN the steady value is 4.
- Impulse: single sample I=127, Q=-128 between zeros:
  - I -> 0,0,0,2,2,0,0,0;
  - Q -> -1,-1,-1,-3,-3,-1,-1,-1;
  - then 0.
- Extremes and independence: hold I=127, Q=-128 -> steady I=7, Q=-8.
- Gaps: toggle sample_ready 1/0 during a step -> outputs change only after accepted samples; postfilter_ready pulses once per accepted sample; the step sequence is the same as back-to-back.
- Reset mid-step: assert reset_n=0 for one cycle during the step sequence -> outputs and ready go to 0; the next step restarts at 0,0,0,1.
